// File: rtl/csr_pkg.sv
// Shared CSR constants for the machine counter block: counter CSR addresses,
// CSR data width and the default counter reset value.
package csr_pkg;

    localparam int unsigned CSR_DW        = 32;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [63:0] CNT_RESET_DEF = 64'h0;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves.
// A write to either half overrides the increment for that cycle.
module csr_counter64
    import csr_pkg::*;
#(
    parameter logic [63:0] CNT_RESET = CNT_RESET_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic [CSR_DW-1:0] wr_data,
    output logic [63:0]       cnt
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Writing one half leaves the other untouched: no carry crosses the boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo) begin
            cnt_d[31:0] = wr_data;
        end else if (wr_hi) begin
            cnt_d[63:32] = wr_data;
        end else if (inc_en) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/machine_counter_ctrl.sv
// mcycle / minstret machine counters: enable qualification from mcountinhibit
// and debug halt, CSR address decode for writes, and a combinational read mux.
module machine_counter_ctrl
    import csr_pkg::*;
#(
    parameter logic [11:0] MCYCLE_ADDR    = CSR_MCYCLE,
    parameter logic [11:0] MINSTRET_ADDR  = CSR_MINSTRET,
    parameter logic [11:0] MCYCLEH_ADDR   = CSR_MCYCLEH,
    parameter logic [11:0] MINSTRETH_ADDR = CSR_MINSTRETH,
    parameter logic [63:0] CNT_RESET      = CNT_RESET_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              mcountinhibit_cy_in,
    input  logic              mcountinhibit_ir_in,
    input  logic              halt_in,
    input  logic              instret_in,
    input  logic [11:0]       csr_addr_in,
    input  logic              wr_en_in,
    input  logic [CSR_DW-1:0] data_wr_in,
    output logic              csr_hit_out,
    output logic [CSR_DW-1:0] csr_rd_data_out,
    output logic [63:0]       mcycle_out,
    output logic [63:0]       minstret_out
);

    logic cy_en;
    logic ir_en;
    logic hit_cy_lo;
    logic hit_cy_hi;
    logic hit_ir_lo;
    logic hit_ir_hi;

    always_comb begin
        cy_en     = !mcountinhibit_cy_in && !halt_in;
        ir_en     = instret_in && !mcountinhibit_ir_in && !halt_in;
        hit_cy_lo = (csr_addr_in == MCYCLE_ADDR);
        hit_cy_hi = (csr_addr_in == MCYCLEH_ADDR);
        hit_ir_lo = (csr_addr_in == MINSTRET_ADDR);
        hit_ir_hi = (csr_addr_in == MINSTRETH_ADDR);
    end

    csr_counter64 #(.CNT_RESET(CNT_RESET)) u_cycle (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .inc_en  (cy_en),
        .wr_lo   (wr_en_in && hit_cy_lo),
        .wr_hi   (wr_en_in && hit_cy_hi),
        .wr_data (data_wr_in),
        .cnt     (mcycle_out)
    );

    csr_counter64 #(.CNT_RESET(CNT_RESET)) u_instret (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .inc_en  (ir_en),
        .wr_lo   (wr_en_in && hit_ir_lo),
        .wr_hi   (wr_en_in && hit_ir_hi),
        .wr_data (data_wr_in),
        .cnt     (minstret_out)
    );

    // Reads return the pre-edge value, so a same-cycle write is not visible yet.
    always_comb begin
        csr_hit_out     = hit_cy_lo || hit_cy_hi || hit_ir_lo || hit_ir_hi;
        csr_rd_data_out = '0;
        if (hit_cy_lo) begin
            csr_rd_data_out = mcycle_out[31:0];
        end else if (hit_cy_hi) begin
            csr_rd_data_out = mcycle_out[63:32];
        end else if (hit_ir_lo) begin
            csr_rd_data_out = minstret_out[31:0];
        end else if (hit_ir_hi) begin
            csr_rd_data_out = minstret_out[63:32];
        end
    end

endmodule
